fb_port_arbiter: RTL and testbench
==================================

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, framebuffer address width.
REQ-002 SHALL have parameter DATA_W, default 8, pixel word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 1023, writer wait cycles before starvation flag; 10-bit.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port rd_en  in  1  scanout fetch request for this cycle (driven from display_en).
REQ-007 SHALL have port rd_addr  in  ADDR_W  scanout fetch address.
REQ-008 SHALL have port rd_data  out  DATA_W  scanout pixel; rd_valid  out  1  qualifier.
REQ-009 SHALL have ports wr_req[1:0]  in  2, wr_addr0/wr_addr1  in  ADDR_W, wr_data0/wr_data1  in  DATA_W: two game-logic writers.
REQ-010 SHALL have port wr_ack[1:0]  out  2  one-cycle write-performed pulse per writer.
REQ-011 SHALL have port vblank  in  1  high outside the vertical active region.
REQ-012 SHALL have ports mem_addr  out  ADDR_W, mem_we  out  1, mem_wdata  out  DATA_W, mem_rdata  in  DATA_W: single-port synchronous RAM, 1-cycle read latency.
REQ-013 SHALL have ports starve_clr  in  1, starved[1:0]  out  2  sticky per-writer starvation flags.

Function
REQ-014 SHALL decide one port owner per cycle (decision cycle N); priority: scanout > writers.
REQ-015 SHALL register mem_addr/mem_we/mem_wdata at N+1 from the cycle-N decision; rd_data = mem_rdata and rd_valid high at N+2 (fixed scanout latency 2).
REQ-016 SHALL, when rd_en=0 and ≥1 eligible writer, grant round-robin: pointer names the preferred writer, flips to the other after every grant.
REQ-017 SHALL pulse wr_ack[i] at N+1, coincident with mem_we=1 for that write.
REQ-018 SHALL treat writer i as ineligible in the cycle following its grant (ack cycle), so a held wr_req is not double-written.
REQ-019 Writers SHALL hold wr_req/addr/data stable until wr_ack; a new request may be presented the cycle after wr_ack.
REQ-020 SHALL drive mem_we=0 and mem_addr=rd_addr-registered in any cycle with no writer grant; idle cycles hold mem_addr.
REQ-021 SHALL count per-writer consecutive cycles with wr_req high and no grant; at count=STARVE_LIMIT set starved[i]; counter saturates, clears on grant.
REQ-022 SHALL clear starved[] on starve_clr; simultaneous set and clear: set wins.
REQ-023 Deassertion of wr_req without ack SHALL be treated as abandonment: counter cleared, no write.

Reset
REQ-024 SHALL on reset low: mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, rd_data=0, wr_ack=0, starved=0, counters=0, RR pointer=writer 0, pipeline discarded.
REQ-025 Reset mid-write SHALL cancel the pending write (no mem_we, no ack after release).

Configuration
REQ-026 SHALL honour macro FB_WR_BLANK_ONLY_EN: defined -> writers eligible only while vblank=1 (tear-free); undefined -> writers eligible in any cycle rd_en=0, vblank ignored.

Structure
REQ-027 Shared package fb_pkg SHALL hold ADDR_W/DATA_W defaults, grant encoding (GNT_NONE, GNT_RD, GNT_W0, GNT_W1), and STARVE_LIMIT default.
REQ-028 One sub-module rr_arb2 (2-way round-robin with pointer and eligibility mask) SHALL be instantiated.

Verification
REQ-029 rd_en high 4 cycles, addrs 0..3, RAM preloaded -> rd_valid high cycles N+2..N+5, data in order; no mem_we.
REQ-030 Both wr_req high, rd_en=0, vblank=1 -> writes alternate W0,W1,W0,W1; each wr_ack one cycle; RAM contents match.
REQ-031 W0 req held during continuous rd_en for 1023 cycles -> starved[0]=1 at cycle 1023; starve_clr -> 0.
REQ-032 FB_WR_BLANK_ONLY_EN defined, vblank=0, rd_en=0, wr_req=01 -> no ack until vblank=1, then ack in 1 cycle.
REQ-033 Reset asserted the cycle after a W1 grant -> no mem_we, no wr_ack, all outputs 0, pointer=0 after release.
REQ-034 Single W0 request held through its ack cycle -> exactly one write and one ack.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer port arbiter.
// Holds the default widths, the starvation limit default and the
// per-cycle port-owner (grant) encoding.
package fb_pkg;

  localparam int unsigned ADDR_W_DEF       = 15;
  localparam int unsigned DATA_W_DEF       = 8;
  localparam int unsigned STARVE_LIMIT_DEF = 1023;
  localparam int unsigned STARVE_CNT_W     = 10;

  // Owner of the RAM port for one decision cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_W0   = 2'd2,
    GNT_W1   = 2'd3
  } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with eligibility mask.
// Ports:
//   clk, reset  - clock, async active-low reset
//   i_elig[1:0] - writers eligible this cycle (already masked by scanout)
//   o_gnt_c[1:0]- one-hot combinational grant for this cycle
// The pointer names the preferred writer and moves to the other writer
// after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_elig,
  output logic [1:0] o_gnt_c
);

  logic r_ptr;

  // Pick the pointed-to writer only when both are eligible
  always_comb begin
    o_gnt_c = 2'b00;
    case (i_elig)
      2'b01:   o_gnt_c = 2'b01;
      2'b10:   o_gnt_c = 2'b10;
      2'b11:   o_gnt_c = r_ptr ? 2'b10 : 2'b01;
      default: o_gnt_c = 2'b00;
    endcase
  end

  // Granting writer 0 points at writer 1 and vice versa
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= 1'b0;
    end else if (|o_gnt_c) begin
      r_ptr <= o_gnt_c[0];
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer single-port RAM arbiter: one scanout reader, two writers.
// Scanout always wins; writers share the leftover cycles round-robin.
// Configuration macro: FB_WR_BLANK_ONLY_EN (defined: writers only during vblank).
// Ports:
//   clk, reset                    - clock, async active-low reset
//   rd_en, rd_addr                - scanout fetch request/address
//   rd_data, rd_valid             - scanout pixel, two cycles after request
//   wr_req, wr_addr0/1, wr_data0/1- writer requests, held until wr_ack
//   wr_ack                        - one-cycle pulse, coincident with mem_we
//   vblank                        - vertical blanking indicator
//   mem_addr/we/wdata, mem_rdata  - synchronous RAM port, 1-cycle read latency
//   starve_clr, starved           - sticky per-writer starvation flags
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_ack,
  input  logic              vblank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              starve_clr,
  output logic [1:0]        starved
);

  logic                         w_blank_ok;
  logic [1:0]                   w_elig;
  logic [1:0]                   w_wgnt;
  logic [1:0]                   w_wait;
  logic [1:0]                   w_set;
  gnt_e                         w_gnt;

  logic [ADDR_W-1:0]            r_addr;
  logic [DATA_W-1:0]            r_wdata;
  logic                         r_we;
  logic [1:0]                   r_ack;
  logic                         r_rd_p1;
  logic                         r_rd_valid;
  logic [1:0]                   r_starved;
  logic [1:0][STARVE_CNT_W-1:0] r_cnt;

`ifdef FB_WR_BLANK_ONLY_EN
  // Tear-free build: writers only touch the framebuffer during blanking
  assign w_blank_ok = vblank;
`else
  // vblank has no effect on eligibility in this build
  assign w_blank_ok = vblank | 1'b1;
`endif

  // A writer in its ack cycle is skipped so a still-held request is not rewritten
  assign w_elig = wr_req & ~r_ack & {2{w_blank_ok & ~rd_en}};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .i_elig  (w_elig),
    .o_gnt_c (w_wgnt)
  );

  // Port owner for this decision cycle
  always_comb begin
    w_gnt = GNT_NONE;
    if (rd_en) begin
      w_gnt = GNT_RD;
    end else if (w_wgnt[0]) begin
      w_gnt = GNT_W0;
    end else if (w_wgnt[1]) begin
      w_gnt = GNT_W1;
    end
  end

  // RAM port registers; idle cycles keep the last address and data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_ack      <= 2'b00;
      r_rd_p1    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_ack      <= 2'b00;
      r_rd_p1    <= (w_gnt == GNT_RD);
      r_rd_valid <= r_rd_p1;
      case (w_gnt)
        GNT_RD: begin
          r_addr <= rd_addr;
        end
        GNT_W0: begin
          r_addr  <= wr_addr0;
          r_wdata <= wr_data0;
          r_we    <= 1'b1;
          r_ack   <= 2'b01;
        end
        GNT_W1: begin
          r_addr  <= wr_addr1;
          r_wdata <= wr_data1;
          r_we    <= 1'b1;
          r_ack   <= 2'b10;
        end
        default: begin
        end
      endcase
    end
  end

  // A writer is waiting when it requests, is not granted and is not in its ack cycle
  assign w_wait = wr_req & ~w_wgnt & ~r_ack;

  // Flag raised once, on the step that brings the counter to the limit
  always_comb begin
    w_set = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_set[i] = w_wait[i] && (r_cnt[i] == STARVE_CNT_W'(STARVE_LIMIT - 1));
    end
  end

  // Saturating wait counters; grant or abandonment restarts them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_starved <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!w_wait[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != STARVE_CNT_W'(STARVE_LIMIT)) begin
          r_cnt[i] <= r_cnt[i] + STARVE_CNT_W'(1);
        end
      end
      r_starved <= (r_starved & ~{2{starve_clr}}) | w_set;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_we    = r_we;
  assign mem_wdata = r_wdata;
  assign wr_ack    = r_ack;
  assign rd_valid  = r_rd_valid;
  // RAM output is already one cycle behind the registered address
  assign rd_data   = r_rd_valid ? mem_rdata : '0;
  assign starved   = r_starved;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter with a behavioural
// single-port synchronous RAM attached to the memory port.
module tb_fb_port_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    wr_req;
  logic [AW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic [1:0]    wr_ack;
  logic          vblank;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          starve_clr;
  logic [1:0]    starved;

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(1023)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_req     (wr_req),
    .wr_addr0   (wr_addr0),
    .wr_addr1   (wr_addr1),
    .wr_data0   (wr_data0),
    .wr_data1   (wr_data1),
    .wr_ack     (wr_ack),
    .vblank     (vblank),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .starve_clr (starve_clr),
    .starved    (starved)
  );

  // Synchronous RAM with a bench-side preload port
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; rd_addr = '0; wr_req = 2'b00;
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    vblank = 1'b1; starve_clr = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_en = 1'b1;
    wr_req = 2'b11;
    reset = 1'b0;
    step();
    step();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    total++; if (mem_wdata !== '0) begin bad++; $display("FAIL reset_mem_wdata got=%0h exp=0", mem_wdata); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0h exp=0", rd_valid); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    total++; if (wr_ack !== 2'b00) begin bad++; $display("FAIL reset_wr_ack got=%0h exp=0", wr_ack); end
    total++; if (starved !== 2'b00) begin bad++; $display("FAIL reset_starved got=%0h exp=0", starved); end
    idle_inputs();
    reset = 1'b1;
    step();
  endtask

  task automatic test_read();
    logic [DW-1:0] pat [4];
    logic          exp_v;
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'h7E; pat[3] = 8'h81;
    do_reset();
    for (int i = 0; i < 4; i++) preload(AW'(i), pat[i]);
    for (int k = 0; k < 7; k++) begin
      rd_en   = (k < 4);
      rd_addr = AW'(k);
      step();
      exp_v = (k >= 1) && (k <= 4);
      total++; if (rd_valid !== exp_v) begin bad++; $display("FAIL read_valid k=%0d got=%0h exp=%0h", k, rd_valid, exp_v); end
      if (exp_v) begin
        total++; if (rd_data !== pat[k-1]) begin bad++; $display("FAIL read_data k=%0d got=%0h exp=%0h", k, rd_data, pat[k-1]); end
      end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL read_no_we k=%0d got=%0h exp=0", k, mem_we); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_alternate();
    logic [AW-1:0] a0 [2], a1 [2], ea [4];
    logic [DW-1:0] d0 [2], d1 [2], ed [4];
    logic [1:0]    eack [6];
    int            idx [2];
    logic [1:0]    pend, inc;
    a0[0] = 15'h010; a0[1] = 15'h011; d0[0] = 8'h5A; d0[1] = 8'h5B;
    a1[0] = 15'h020; a1[1] = 15'h021; d1[0] = 8'hC3; d1[1] = 8'hC4;
    ea[0] = 15'h010; ea[1] = 15'h020; ea[2] = 15'h011; ea[3] = 15'h021;
    ed[0] = 8'h5A;   ed[1] = 8'hC3;   ed[2] = 8'h5B;   ed[3] = 8'hC4;
    eack[0] = 2'b01; eack[1] = 2'b10; eack[2] = 2'b01; eack[3] = 2'b10;
    eack[4] = 2'b00; eack[5] = 2'b00;
    idx[0] = 0; idx[1] = 0; pend = 2'b00; inc = 2'b00;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      // Writers hold through the ack cycle and move on one cycle later
      for (int i = 0; i < 2; i++) begin
        if (inc[i]) begin idx[i]++; inc[i] = 1'b0; end
        if (pend[i]) begin inc[i] = 1'b1; pend[i] = 1'b0; end
      end
      wr_req[0] = (idx[0] < 2);
      wr_req[1] = (idx[1] < 2);
      wr_addr0 = a0[idx[0] % 2]; wr_data0 = d0[idx[0] % 2];
      wr_addr1 = a1[idx[1] % 2]; wr_data1 = d1[idx[1] % 2];
      step();
      pend = wr_ack;
      total++; if (wr_ack !== eack[k]) begin bad++; $display("FAIL alt_ack k=%0d got=%0h exp=%0h", k, wr_ack, eack[k]); end
      total++; if (mem_we !== (k < 4)) begin bad++; $display("FAIL alt_we k=%0d got=%0h exp=%0h", k, mem_we, (k < 4)); end
      if (k < 4) begin
        total++; if (mem_addr !== ea[k]) begin bad++; $display("FAIL alt_addr k=%0d got=%0h exp=%0h", k, mem_addr, ea[k]); end
        total++; if (mem_wdata !== ed[k]) begin bad++; $display("FAIL alt_wdata k=%0d got=%0h exp=%0h", k, mem_wdata, ed[k]); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (ram[ea[k]] !== ed[k]) begin bad++; $display("FAIL alt_ram a=%0h got=%0h exp=%0h", ea[k], ram[ea[k]], ed[k]); end
    end
  endtask

  task automatic test_starve();
    int acks;
    acks = 0;
    do_reset();
    rd_en = 1'b1; wr_req = 2'b01; wr_addr0 = 15'h100; wr_data0 = 8'h99;
    repeat (1022) begin
      step();
      acks += int'(wr_ack[0]);
    end
    total++; if (starved !== 2'b00) begin bad++; $display("FAIL starve_1022 got=%0h exp=0", starved); end
    step();
    total++; if (starved !== 2'b01) begin bad++; $display("FAIL starve_1023 got=%0h exp=1", starved); end
    repeat (5) begin
      step();
      acks += int'(wr_ack[0]);
    end
    total++; if (starved !== 2'b01) begin bad++; $display("FAIL starve_sticky got=%0h exp=1", starved); end
    total++; if (acks !== 0) begin bad++; $display("FAIL starve_no_ack got=%0d exp=0", acks); end
    starve_clr = 1'b1;
    step();
    starve_clr = 1'b0;
    total++; if (starved !== 2'b00) begin bad++; $display("FAIL starve_clr got=%0h exp=0", starved); end
    step();
    total++; if (starved !== 2'b00) begin bad++; $display("FAIL starve_no_reset got=%0h exp=0", starved); end
    rd_en = 1'b0;
    step();
    total++; if (wr_ack !== 2'b01) begin bad++; $display("FAIL starve_late_ack got=%0h exp=1", wr_ack); end
    total++; if (mem_addr !== 15'h100) begin bad++; $display("FAIL starve_late_addr got=%0h exp=100", mem_addr); end
    wr_req = 2'b00;
    step();
    // Writer 1 gives up before being served: nothing may be written
    rd_en = 1'b1; wr_req = 2'b10; wr_addr1 = 15'h180; wr_data1 = 8'h42;
    repeat (3) step();
    wr_req = 2'b00; rd_en = 1'b0;
    step();
    total++; if (mem_we !== 1'b0 || wr_ack !== 2'b00) begin bad++; $display("FAIL abandon got_we=%0h got_ack=%0h exp=0", mem_we, wr_ack); end
  endtask

  task automatic test_blank();
    do_reset();
    vblank = 1'b0; wr_req = 2'b01; wr_addr0 = 15'h0A0; wr_data0 = 8'h66;
`ifdef FB_WR_BLANK_ONLY_EN
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (wr_ack !== 2'b00) begin bad++; $display("FAIL blank_hold k=%0d got=%0h exp=0", k, wr_ack); end
    end
    vblank = 1'b1;
`endif
    step();
    total++; if (wr_ack !== 2'b01) begin bad++; $display("FAIL blank_ack got=%0h exp=1", wr_ack); end
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL blank_we got=%0h exp=1", mem_we); end
    wr_req = 2'b00;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    preload(15'h201, 8'hEE);
    wr_req = 2'b01; wr_addr0 = 15'h200; wr_data0 = 8'h11;
    step();
    wr_req = 2'b10; wr_addr1 = 15'h201; wr_data1 = 8'h22;
    step();
    total++; if (wr_ack !== 2'b10) begin bad++; $display("FAIL rmid_pre_ack got=%0h exp=2", wr_ack); end
    reset = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmid_we got=%0h exp=0", mem_we); end
    total++; if (wr_ack !== 2'b00) begin bad++; $display("FAIL rmid_ack got=%0h exp=0", wr_ack); end
    total++; if (mem_addr !== '0 || mem_wdata !== '0) begin bad++; $display("FAIL rmid_addr_data got=%0h/%0h exp=0/0", mem_addr, mem_wdata); end
    wr_req = 2'b00;
    step();
    reset = 1'b1;
    step();
    total++; if (mem_we !== 1'b0 || wr_ack !== 2'b00) begin bad++; $display("FAIL rmid_after got_we=%0h got_ack=%0h exp=0", mem_we, wr_ack); end
    total++; if (ram[15'h201] !== 8'hEE) begin bad++; $display("FAIL rmid_ram got=%0h exp=ee", ram[15'h201]); end
    wr_req = 2'b11; wr_addr0 = 15'h202; wr_data0 = 8'h33; wr_addr1 = 15'h203; wr_data1 = 8'h44;
    step();
    total++; if (wr_ack !== 2'b01) begin bad++; $display("FAIL rmid_ptr got=%0h exp=1", wr_ack); end
    wr_req = 2'b00;
    step();
  endtask

  task automatic test_single();
    int n_ack, n_we;
    n_ack = 0; n_we = 0;
    do_reset();
    wr_req = 2'b01; wr_addr0 = 15'h300; wr_data0 = 8'h77;
    step();
    n_ack += int'(wr_ack[0]); n_we += int'(mem_we);
    step();
    n_ack += int'(wr_ack[0]); n_we += int'(mem_we);
    wr_req = 2'b00;
    repeat (2) begin
      step();
      n_ack += int'(wr_ack[0]); n_we += int'(mem_we);
    end
    total++; if (n_ack !== 1) begin bad++; $display("FAIL single_acks got=%0d exp=1", n_ack); end
    total++; if (n_we !== 1) begin bad++; $display("FAIL single_writes got=%0d exp=1", n_we); end
    total++; if (ram[15'h300] !== 8'h77) begin bad++; $display("FAIL single_ram got=%0h exp=77", ram[15'h300]); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_read();
    test_alternate();
    test_starve();
    test_blank();
    test_reset_mid();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
